stream_chunk_sum: RTL

//   Downstream consumer of the zip_add output stream. Accumulates accepted stream

---
 rtl/stream_chunk_sum.sv | 63 ++++++
 1 files changed

// File: rtl/stream_chunk_sum.sv
// Accumulates a valid/ready element stream and emits one registered sum per CHUNK
// elements, or an early partial sum when flush is pulsed.
module stream_chunk_sum #(
  parameter int N     = 8,
  parameter int CHUNK = 4,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     sIn,
  input  logic             sIn_valid,
  output logic             sIn_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] sOut,
  output logic [4:0]       sOut_count,
  output logic             sOut_valid,
  input  logic             sOut_ready
);

  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] sum_next;
  logic [4:0]       cnt;
  logic [4:0]       total;
  logic             in_beat;
  logic             out_beat;
  logic             emit;

  // Input stalls only while a finished sum is still waiting for the consumer.
  assign sIn_ready = !sOut_valid || sOut_ready;
  assign in_beat   = sIn_valid && sIn_ready;
  assign out_beat  = sOut_valid && sOut_ready;

  // Sum and element count including this cycle's beat; the sum wraps at OUT_W bits.
  assign sum_next = in_beat ? acc + OUT_W'(sIn) : acc;
  assign total    = in_beat ? cnt + 5'd1 : cnt;

  // A full chunk always emits; flush emits only a non-empty partial and never
  // while the output register is held.
  assign emit = (total == 5'(CHUNK)) || (flush && sIn_ready && (total != 5'd0));

  // NOTE: every register here uses <= so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      sOut       <= '0;
      sOut_count <= '0;
      sOut_valid <= 1'b0;
    end else if (emit) begin
      // Loading a new sum while the old one drains keeps sOut_valid high.
      sOut       <= sum_next;
      sOut_count <= total;
      sOut_valid <= 1'b1;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      acc <= sum_next;
      cnt <= total;
      if (out_beat) sOut_valid <= 1'b0;
    end
  end

endmodule
